// File: rtl/if_fetch.sv
`timescale 1ns/1ps
// Instruction-fetch stage: owns the fetch PC, issues one imem request at a time
// and drives the IF/ID register, honouring ID stall and branch redirect.
module if_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction,
  output logic [31:0] pc,
  output logic        id_valid
);

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] PC_STEP  = XLEN'(4);
  localparam logic [XLEN-1:0] ALIGN_MSK = 32'hFFFF_FFFC;

  localparam logic [1:0] S_FETCH = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;

  logic [1:0]      r_state;
  logic [XLEN-1:0] r_pc_f;
  logic            r_kill;
  logic [XLEN-1:0] r_buf_instr;
  logic [XLEN-1:0] r_buf_pc;
  logic [XLEN-1:0] r_instr;
  logic [XLEN-1:0] r_pc;
  logic            r_id_valid;

  logic [1:0]      w_state_nxt;
  logic [XLEN-1:0] w_pc_f_nxt;
  logic            w_kill_nxt;
  logic [XLEN-1:0] w_buf_instr_nxt;
  logic [XLEN-1:0] w_buf_pc_nxt;
  logic [XLEN-1:0] w_instr_nxt;
  logic [XLEN-1:0] w_pc_nxt;
  logic            w_id_valid_nxt;

  logic            w_handshake;
  logic            w_idif_free;
  logic [XLEN-1:0] w_redirect_tgt;

  assign imem_req       = (r_state == S_FETCH) && !redirect;
  assign imem_addr      = r_pc_f;
  assign w_handshake    = imem_req && imem_ready;
  assign w_idif_free    = !stall || !r_id_valid;
  assign w_redirect_tgt = redirect_pc & ALIGN_MSK;

  assign instruction = r_instr;
  assign pc          = r_pc;
  assign id_valid    = r_id_valid;

  // Next-state and IF/ID update; redirect is applied last so it overrides everything
  always_comb begin
    w_state_nxt     = r_state;
    w_pc_f_nxt      = r_pc_f;
    w_kill_nxt      = r_kill;
    w_buf_instr_nxt = r_buf_instr;
    w_buf_pc_nxt    = r_buf_pc;
    w_instr_nxt     = r_instr;
    w_pc_nxt        = r_pc;
    w_id_valid_nxt  = r_id_valid;

    if (!stall) begin
      w_instr_nxt    = NOP_INSTR;
      w_id_valid_nxt = 1'b0;
    end

    case (r_state)
      S_FETCH: begin
        if (w_handshake) w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          w_state_nxt = S_FETCH;
          if (r_kill) begin
            w_kill_nxt = 1'b0;
          end else begin
            w_pc_f_nxt = r_pc_f + PC_STEP;
            if (w_idif_free) begin
              w_instr_nxt    = imem_rdata;
              w_pc_nxt       = r_pc_f;
              w_id_valid_nxt = 1'b1;
            end else begin
              w_buf_instr_nxt = imem_rdata;
              w_buf_pc_nxt    = r_pc_f;
              w_state_nxt     = S_HOLD;
            end
          end
        end
      end
      S_HOLD: begin
        if (!stall) begin
          w_instr_nxt    = r_buf_instr;
          w_pc_nxt       = r_buf_pc;
          w_id_valid_nxt = 1'b1;
          w_state_nxt    = S_FETCH;
        end
      end
      default: begin
        w_state_nxt = S_FETCH;
      end
    endcase

    if (redirect) begin
      w_instr_nxt    = NOP_INSTR;
      w_id_valid_nxt = 1'b0;
      w_pc_f_nxt     = w_redirect_tgt;
      // A request still in flight must have its response dropped when it lands
      if ((r_state == S_WAIT) && !imem_rvalid) begin
        w_state_nxt = S_WAIT;
        w_kill_nxt  = 1'b1;
      end else begin
        w_state_nxt = S_FETCH;
        w_kill_nxt  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc_f      <= RESET_PC;
      r_kill      <= 1'b0;
      r_buf_instr <= '0;
      r_buf_pc    <= '0;
      r_instr     <= NOP_INSTR;
      r_pc        <= '0;
      r_id_valid  <= 1'b0;
    end else begin
      r_pc_f      <= w_pc_f_nxt;
      r_kill      <= w_kill_nxt;
      r_buf_instr <= w_buf_instr_nxt;
      r_buf_pc    <= w_buf_pc_nxt;
      r_instr     <= w_instr_nxt;
      r_pc        <= w_pc_nxt;
      r_id_valid  <= w_id_valid_nxt;
    end
  end

endmodule
